// File: rtl/register_file_param.sv
// Parametrised multi-port register file with a two-port write path, optional write-to-read
// bypass and a pending-write scoreboard used by decode to stall on outstanding producers.
module register_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [ADDR_W:0]            pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pending_q;
    logic [DEPTH-1:0]  pending_d;
    logic [ADDR_W:0]   pendCnt_q;
    logic [ADDR_W:0]   pendCnt_d;

    logic we0Eff;
    logic we1Eff;
    logic rsvEff;

    // With a hardwired zero register, anything aimed at address 0 simply never happens.
    assign we0Eff = we0 && !(ZERO_REG != 0 && waddr0 == '0);
    assign we1Eff = we1 && !(ZERO_REG != 0 && waddr1 == '0);
    assign rsvEff = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

    // Port 1 is applied last so it wins a same-address collision with port 0.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we0Eff) begin
            regs_d[waddr0] = wdata0;
        end
        if (we1Eff) begin
            regs_d[waddr1] = wdata1;
        end
    end

    // The reserve is applied after the clears so a newer producer keeps the register pending.
    always_comb begin
        pending_d = pending_q;
        if (we0Eff) begin
            pending_d[waddr0] = 1'b0;
        end
        if (we1Eff) begin
            pending_d[waddr1] = 1'b0;
        end
        if (rsvEff) begin
            pending_d[rsv_addr] = 1'b1;
        end
    end

    // The count is taken from the next-state vector so it never lags the pending bits.
    always_comb begin
        pendCnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pendCnt_d = pendCnt_d + {{ADDR_W{1'b0}}, pending_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
            pendCnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q <= pending_d;
            pendCnt_q <= pendCnt_d;
        end
    end

    assign pend_cnt = pendCnt_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] rdAddr;
        logic [DATA_W-1:0] rdPort;
        logic              busyPort;

        assign rdAddr = raddr[p*ADDR_W +: ADDR_W];

        // A forwarded write is about to land, so the reader is no longer waiting on it.
        always_comb begin
            rdPort   = regs_q[rdAddr];
            busyPort = pending_q[rdAddr];
            if (ZERO_REG != 0 && rdAddr == '0) begin
                rdPort   = '0;
                busyPort = 1'b0;
            end else if (BYPASS != 0 && we1Eff && waddr1 == rdAddr) begin
                rdPort   = wdata1;
                busyPort = 1'b0;
            end else if (BYPASS != 0 && we0Eff && waddr0 == rdAddr) begin
                rdPort   = wdata0;
                busyPort = 1'b0;
            end
        end

        assign rdata[p*DATA_W +: DATA_W] = rdPort;
        assign rd_busy[p]                = busyPort;
    end

endmodule
